// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default address width and Gray-code helpers.
// Used by both the write-pointer and read-pointer blocks.
package fifo_pkg;

    localparam int ASIZE_DEF = 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync_r2w.sv
// Two-flop synchronizer bringing the Gray read pointer into wclk.
// Resets synchronously to zero.
module fifo_sync_r2w #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q1;

    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost-full flags, level and overflow
// tracking for an asynchronous FIFO.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int ASIZE     = ASIZE_DEF,
    parameter int AF_THRESH = 2**ASIZE - 2
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             winc,
    input  logic [ASIZE:0]   rptr,
    output logic             wen,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    output logic             wovf
);

    localparam logic [ASIZE:0] AF_LVL = (ASIZE+1)'(AF_THRESH);

    logic [ASIZE:0] wbin;
    logic [ASIZE:0] wbin_next;
    logic [ASIZE:0] wgray_next;
    logic [ASIZE:0] wq2_rptr;
    logic [ASIZE:0] rbin;
    logic [ASIZE:0] wlevel_next;
    logic           wfull_next;

    fifo_sync_r2w #(
        .W(ASIZE+1)
    ) u_sync (
        .clk(wclk),
        .rst(wrst),
        .d  (rptr),
        .q  (wq2_rptr)
    );

    assign wen        = winc & ~wfull;
    assign waddr      = wbin[ASIZE-1:0];
    assign wbin_next  = wbin + {{ASIZE{1'b0}}, wen};
    assign wgray_next = (ASIZE+1)'(bin2gray(32'(wbin_next)));
    assign rbin       = (ASIZE+1)'(gray2bin(32'(wq2_rptr)));
    assign wlevel_next = wbin_next - rbin;

    // Full when write pointer has lapped the read pointer by one depth
    assign wfull_next = (wgray_next ==
        {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            wlevel       <= '0;
            walmost_full <= 1'b0;
            wovf         <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= wfull_next;
            wlevel       <= wlevel_next;
            walmost_full <= (wlevel_next >= AF_LVL);
            wovf         <= wovf | (winc & wfull);
        end
    end

endmodule
